// File: rtl/unidad_writeback.sv
// unidad_writeback: owns the register bank write port, merging ALU results with in-order variable-latency load returns
module unidad_writeback #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] pending_mask,
  output logic        resp_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    hd, tl, fidx, idx;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    starve;
  logic             found, all_filled, load_req, alu_req, load_prio;
  logic             head_commit, alu_commit, issue_ok, head_wr;
  logic [31:0]      mask;
  // find the oldest unfilled entry and collect outstanding destinations
  always_comb begin
    found = 1'b0;
    fidx = '0;
    idx = '0;
    all_filled = 1'b1;
    mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = hd + PW'(k);
      if (CW'(k) < cnt) begin
        if (!filled[idx]) begin
          all_filled = 1'b0;
          if (!found) begin
            found = 1'b1;
            fidx = idx;
          end
        end
        mask[rd_q[idx]] = 1'b1;
      end
    end
    mask = mask | (wb_we ? (32'd1 << wb_rd) : 32'd0);
    mask[0] = 1'b0;
  end
  assign pending_mask = mask;
  assign ld_ready = cnt < CW'(DEPTH);
  assign issue_ok = ld_issue && ld_ready;
  assign load_req = (cnt != '0) && filled[hd];
  assign alu_req = alu_valid && (alu_rd != 5'd0);
  assign load_prio = load_req && ((cnt == CW'(DEPTH) && all_filled) || starve >= SW'(STARVE_LIMIT));
  assign alu_ready = !(load_prio && alu_req);
  assign head_commit = load_req && (load_prio || !alu_req);
  assign alu_commit = alu_req && !head_commit;
  assign head_wr = head_commit && (rd_q[hd] != 5'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd <= '0;
      tl <= '0;
      cnt <= '0;
      filled <= '0;
      starve <= '0;
      resp_err <= 1'b0;
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      if (head_commit) hd <= hd + 1'b1;
      if (issue_ok) begin
        tl <= tl + 1'b1;
        filled[tl] <= 1'b0;
      end
      if (mem_valid && found) filled[fidx] <= 1'b1;
      if (mem_valid && !found) resp_err <= 1'b1;
      cnt <= cnt + CW'(issue_ok) - CW'(head_commit);
      starve <= (head_commit || !load_req) ? '0 : starve + SW'(starve != '1);
      wb_we <= head_wr || alu_commit;
      if (alu_commit) begin
        wb_rd <= alu_rd;
        wb_data <= alu_data;
      end else if (head_wr) begin
        wb_rd <= rd_q[hd];
        wb_data <= data_q[hd];
      end
    end
  end
  // payload storage needs no reset: validity lives in cnt/filled
  always_ff @(posedge clk) begin
    if (issue_ok) rd_q[tl] <= ld_rd;
    if (mem_valid && found) data_q[fidx] <= mem_data;
  end
endmodule
